fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 n_reset  input  1  asynchronous active-low reset.
REQ-004 rom_addr  output  4  instruction ROM address; registered.
REQ-005 rom_data  input  8  ROM read data; valid one cycle after rom_addr is driven.
REQ-006 pc  output  4  address of the instruction currently being fetched or held.
REQ-007 instr  output  8  captured instruction: [7:4] opcode, [3:0] immediate.
REQ-008 instr_valid  output  1  instr holds a fetched instruction awaiting acceptance.
REQ-009 instr_ready  input  1  decode side accepts instr this cycle.
REQ-010 jmp_en  input  1  load jmp_addr as next pc on acceptance.
REQ-011 jmp_addr  input  4  jump target.
REQ-012 pc_wrap  output  1  one-cycle pulse when pc advances from 4'hF to 4'h0 by increment.

Function
REQ-013 The FSM SHALL have exactly three states: REQ, WAIT, HOLD.
REQ-014 REQ: rom_addr = pc, instr_valid = 0; next state WAIT unconditionally.
REQ-015 WAIT: the edge ending WAIT SHALL capture rom_data into instr; next state HOLD.
REQ-016 HOLD: instr_valid = 1; instr and pc SHALL stay stable while instr_ready = 0.
REQ-017 Acceptance SHALL be instr_valid && instr_ready on a rising edge; on acceptance next state = REQ.
REQ-018 On acceptance with jmp_en = 1, pc SHALL become jmp_addr.
REQ-019 On acceptance with jmp_en = 0, pc SHALL become pc + 1 modulo 16.
REQ-020 jmp_en and jmp_addr SHALL be ignored in any cycle without acceptance.
REQ-021 Jump to the current pc SHALL re-fetch the same address; it is not an error.
REQ-022 pc_wrap SHALL be 1 in exactly the cycle after an increment from 4'hF to 4'h0.
REQ-023 pc_wrap SHALL be 0 when a jump targets 4'h0.
REQ-024 Latency from entering REQ to instr_valid = 1 SHALL be 2 cycles.
REQ-025 Maximum throughput SHALL be one instruction per 3 cycles.
REQ-026 instr_ready in REQ or WAIT SHALL have no effect.
REQ-027 rom_addr SHALL change only on the transition into REQ.
REQ-028 rom_addr SHALL equal pc at all times outside reset.

Reset
REQ-029 n_reset low SHALL immediately force the state to REQ, clear pc, rom_addr, instr, instr_valid and pc_wrap to 0, with no clock required.
REQ-030 Reset asserted mid-operation in WAIT or HOLD SHALL discard the pending instruction.
REQ-031 After reset release, the first rising edge SHALL act as a REQ cycle for address 4'h0.
REQ-032 After reset release, instr_valid SHALL first rise 2 cycles after that edge.

Verification
REQ-033 Reset, ROM[0]=8'h31, instr_ready=1 held -> instr_valid=1 with instr=8'h31 and pc=0, 2 cycles after release; pc=1 the cycle after acceptance.
REQ-034 instr_ready=0 for 5 cycles in HOLD with pc=3, ROM[3]=8'hA7 -> instr=8'hA7, pc=3, instr_valid=1 stable throughout; accepted on the first ready cycle.
REQ-035 Accept at pc=2 with jmp_en=1, jmp_addr=4'hC -> next rom_addr=4'hC, pc_wrap=0; jmp_en pulsed in WAIT -> ignored.
REQ-036 Run sequentially through pc=4'hF with instr_ready=1 -> pc=4'h0 and a single-cycle pc_wrap=1; a jump to 0 -> pc_wrap=0.
REQ-037 n_reset pulsed low in HOLD at pc=7 -> instr_valid=0 and pc=0 asynchronously; first instruction after release is ROM[0].

Source files
------------

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch sequencer (REQ -> WAIT -> HOLD) against a 1-cycle-latency ROM.
// Latency: instr_valid rises 2 cycles after entering REQ; at most one instruction per 3 cycles.
// Backpressure: HOLD keeps instr/pc stable until instr_valid && instr_ready; jump/increment applies only then.
module fetch_unit (
    input  logic       clk,
    input  logic       n_reset,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [3:0] pc,
    output logic [7:0] instr,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       jmp_en,
    input  logic [3:0] jmp_addr,
    output logic       pc_wrap
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] rom_addr_q, rom_addr_d;
    logic [7:0] instr_q, instr_d;
    logic       instr_valid_q, instr_valid_d;
    logic       pc_wrap_q, pc_wrap_d;
    logic [3:0] next_pc;
    logic       accept;

    // Valid is only ever high in HOLD, so this is also "HOLD and ready".
    assign accept = instr_valid_q && instr_ready;

    // Address of the next fetch once the held instruction is taken.
    always_comb begin
        next_pc = pc_q + 4'd1;
        if (jmp_en) begin
            next_pc = jmp_addr;
        end
    end

    // Next-state logic: every output is registered, so all of it is computed here.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rom_addr_d    = rom_addr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_wrap_d     = 1'b0;
        case (state_q)
            S_REQ: begin
                // rom_addr already equals pc; the ROM samples it on this edge.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                instr_d       = rom_data;
                instr_valid_d = 1'b1;
                state_d       = S_HOLD;
            end
            S_HOLD: begin
                if (accept) begin
                    state_d       = S_REQ;
                    instr_valid_d = 1'b0;
                    pc_d          = next_pc;
                    // rom_addr moves together with pc, only when entering REQ.
                    rom_addr_d    = next_pc;
                    // Wrap is an increment-only event; a jump to 0 never flags it.
                    pc_wrap_d     = !jmp_en && (pc_q == 4'hF);
                end
            end
            default: begin
                state_d       = S_REQ;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight fetch and restarts at address 0.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= S_REQ;
            pc_q          <= 4'h0;
            rom_addr_q    <= 4'h0;
            instr_q       <= 8'h00;
            instr_valid_q <= 1'b0;
            pc_wrap_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rom_addr_q    <= rom_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_wrap_q     <= pc_wrap_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_wrap     = pc_wrap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed + random checking of fetch_unit against a latency-based reference model.
// Latency: model expects valid 2 edges after each fetch starts and instr == ROM[pc] while valid.
// Backpressure: instr_ready/jmp_en are randomised; the model applies jumps/increments only on acceptance.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic [3:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [3:0] pc;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       jmp_en = 1'b0;
    logic [3:0] jmp_addr = 4'h0;
    logic       pc_wrap;

    logic [7:0] mem [16];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current pc, edges since the fetch began, expected wrap pulse.
    int m_pc   = 0;
    int m_age  = 0;
    int m_wrap = 0;

    fetch_unit dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .pc_wrap     (pc_wrap)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       {28'd0, pc},       m_pc);
        check({tag, ".rom_addr"}, {28'd0, rom_addr}, m_pc);
        check({tag, ".valid"},    {31'd0, instr_valid}, (m_age >= 2) ? 1 : 0);
        check({tag, ".wrap"},     {31'd0, pc_wrap},  m_wrap);
        if (m_age >= 2) begin
            check({tag, ".instr"}, {24'd0, instr}, {24'd0, mem[m_pc]});
        end
    endtask

    // One clock edge: advance the model from the inputs present at the edge, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        if (m_age >= 2 && instr_ready) begin
            if (jmp_en) begin
                m_wrap = 0;
                m_pc   = jmp_addr;
            end else begin
                m_wrap = (m_pc == 15) ? 1 : 0;
                m_pc   = (m_pc + 1) % 16;
            end
            m_age = 0;
        end else begin
            m_wrap = 0;
            if (m_age < 2) m_age++;
        end
        #1;
        check_all(tag);
    endtask

    // Called mid-cycle; outputs must clear with no clock edge.
    task automatic reset_pulse(input string tag);
        n_reset = 1'b0;
        #1;
        m_pc   = 0;
        m_age  = 0;
        m_wrap = 0;
        check_all(tag);
        #1;
        n_reset = 1'b1;
    endtask

    // Stream with ready high until the DUT enters REQ at target.
    task automatic run_to(input int target);
        instr_ready = 1'b1;
        jmp_en      = 1'b0;
        for (int k = 0; k < 80 && m_pc != target; k++) tick("run");
        check("run_to", {28'd0, pc}, target);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h31;
        mem[3] = 8'hA7;

        // Reset state and first fetch of ROM[0] with ready held high.
        instr_ready = 1'b1;
        #1;
        reset_pulse("reset");
        tick("first_req");
        tick("first_valid");
        check("first_instr", {24'd0, instr}, 32'h31);
        tick("first_accept");
        check("pc_after_accept", {28'd0, pc}, 1);

        // Jump request while in WAIT and in stalled HOLD must be ignored.
        run_to(2);
        tick("to_wait");
        jmp_en = 1'b1; jmp_addr = 4'h9; instr_ready = 1'b1;
        tick("jmp_in_wait");
        instr_ready = 1'b0;
        tick("jmp_in_hold_stalled");
        instr_ready = 1'b1; jmp_addr = 4'hC;
        tick("jmp_accept");
        check("jmp_rom_addr", {28'd0, rom_addr}, 32'hC);
        jmp_en = 1'b0;

        // Sequential run from C through F wraps to 0 and on to 3.
        run_to(3);

        // Five stalled HOLD cycles at pc=3.
        instr_ready = 1'b0;
        tick("p3_req");
        tick("p3_wait");
        for (int k = 0; k < 5; k++) tick("p3_stall");
        instr_ready = 1'b1;
        tick("p3_accept");

        // Jump to current pc, then jump to 0 (no wrap pulse).
        run_to(5);
        instr_ready = 1'b0;
        tick("p5_req");
        tick("p5_wait");
        instr_ready = 1'b1; jmp_en = 1'b1; jmp_addr = 4'h5;
        tick("self_jump");
        tick("self_req_wait");
        tick("self_hold");
        jmp_addr = 4'h0;
        tick("jump_zero");
        jmp_en = 1'b0;

        // Reset in HOLD at pc=7, then refetch ROM[0].
        run_to(7);
        instr_ready = 1'b0;
        tick("p7_req");
        tick("p7_wait");
        reset_pulse("reset_in_hold");
        instr_ready = 1'b1;
        tick("post_rst_req");
        tick("post_rst_valid");

        // Randomised traffic, including jumps to self and to F for wrap coverage.
        for (int k = 0; k < 400; k++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            jmp_en      = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       jmp_addr = 4'(m_pc);
                1:       jmp_addr = 4'hF;
                default: jmp_addr = 4'($urandom_range(0, 15));
            endcase
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
